// File: rtl/chaotic_ewma_engine_pkg.sv
// Shared constants, helpers and FSM encoding for the chaotic EWMA engine.
package chaotic_pkg;

    localparam int unsigned DefW          = 16;
    localparam int unsigned DefRW         = 8;
    localparam int unsigned DefRFRAC      = 5;
    localparam int unsigned DefN          = 4;
    localparam int unsigned DefAlphaShift = 2;

    typedef enum logic [1:0] {IDLE, MUL1, MUL2, OUT} state_t;

    function automatic logic [63:0] one_w(input int unsigned w);
        return 64'd1 << w;
    endfunction

    function automatic logic [63:0] sat_w(input logic [63:0] v, input int unsigned w);
        logic [63:0] max_v;
        max_v = one_w(w) - 64'd1;
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/chaotic_ewma_engine_if.sv
// Result beat bus: valid/ready handshake carrying channel, new x and new avg.
interface chaotic_ewma_engine_if
    import chaotic_pkg::*;
#(
    parameter int unsigned W   = DefW,
    parameter int unsigned CHW = 2
) ();

    logic           out_valid;
    logic           out_ready;
    logic [CHW-1:0] out_ch;
    logic [W-1:0]   out_x;
    logic [W-1:0]   out_avg;

    modport master (output out_valid, output out_ch, output out_x, output out_avg,
                    input out_ready);
    modport slave  (input out_valid, input out_ch, input out_x, input out_avg,
                    output out_ready);

endinterface

// File: rtl/chaotic_ewma_engine_lmap_step.sv
// Logistic-map datapath: registered p = x(1-x), then saturated y = r*p.
module lmap_step
    import chaotic_pkg::*;
#(
    parameter int unsigned W     = DefW,
    parameter int unsigned RW    = DefRW,
    parameter int unsigned RFRAC = DefRFRAC
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [W-1:0]  x,
    input  logic [RW-1:0] r,
    output logic [W-1:0]  y
);

    logic [W:0]      one_minus_x;
    logic [2*W:0]    prod;
    logic [W-1:0]    p_d;
    logic [W-1:0]    p_q;
    logic [RW+W-1:0] rp;
    logic [RW+W-1:0] y_full;

    // W+1 bits so that x=0 gives 2^W rather than wrapping to 0.
    always_comb begin
        one_minus_x = (W+1)'(one_w(W)) - {1'b0, x};
        prod        = (2*W+1)'(x) * (2*W+1)'(one_minus_x);
        p_d         = W'(prod >> W);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p_q <= '0;
        end else if (load) begin
            p_q <= p_d;
        end
    end

    always_comb begin
        rp     = (RW+W)'(r) * (RW+W)'(p_q);
        y_full = rp >> RFRAC;
        y      = W'(sat_w(64'(y_full), W));
    end

endmodule

// File: rtl/chaotic_ewma_engine.sv
// Round-robin multi-channel logistic-map noise source with per-channel EWMA
// smoothing, sharing one lmap_step datapath.
module chaotic_ewma_engine
    import chaotic_pkg::*;
#(
    parameter int unsigned W           = DefW,
    parameter int unsigned RW          = DefRW,
    parameter int unsigned RFRAC       = DefRFRAC,
    parameter int unsigned N           = DefN,
    parameter int unsigned ALPHA_SHIFT = DefAlphaShift,
    parameter int unsigned CHW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   seed_load,
    input  logic [CHW-1:0]         seed_ch,
    input  logic [W-1:0]           seed_val,
    input  logic [RW-1:0]          r_val,
    output logic                   busy,
    chaotic_ewma_engine_if.master  beat
);

    logic [W-1:0]   x_q   [N];
    logic [W-1:0]   avg_q [N];
    logic [RW-1:0]  r_q   [N];

    state_t         state_q;
    logic [CHW-1:0] ch_q;
    logic           valid_q;
    logic [CHW-1:0] out_ch_q;
    logic [W-1:0]   out_x_q;
    logic [W-1:0]   out_avg_q;
    logic           busy_q;

    logic [W-1:0]   y;
    logic [W-1:0]   avg_cur;
    logic signed [W:0] d;
    logic signed [W:0] d_sh;
    logic signed [W:0] avg_sum;
    logic [W-1:0]   avg_next;
    logic           seed_hit;
    logic [CHW-1:0] ch_next;

    lmap_step #(
        .W     (W),
        .RW    (RW),
        .RFRAC (RFRAC)
    ) u_lmap_step (
        .clock (clock),
        .reset (reset),
        .load  (state_q == MUL1),
        .x     (x_q[ch_q]),
        .r     (r_q[ch_q]),
        .y     (y)
    );

    // Arithmetic shift on the signed difference floors toward minus infinity.
    always_comb begin
        avg_cur  = avg_q[ch_q];
        d        = signed'({1'b0, y}) - signed'({1'b0, avg_cur});
        d_sh     = d >>> ALPHA_SHIFT;
        avg_sum  = signed'({1'b0, avg_cur}) + d_sh;
        avg_next = avg_sum[W-1:0];
        seed_hit = seed_load && (32'(seed_ch) < N);
        ch_next  = (ch_q == CHW'(N - 1)) ? '0 : ch_q + CHW'(1);
    end

    // Seed write sits after the commit so it wins a same-channel collision.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(N); i++) begin
                x_q[i]   <= '0;
                avg_q[i] <= '0;
                r_q[i]   <= '0;
            end
        end else begin
            if (state_q == MUL2) begin
                x_q[ch_q]   <= y;
                avg_q[ch_q] <= avg_next;
            end
            if (seed_hit) begin
                x_q[seed_ch]   <= seed_val;
                avg_q[seed_ch] <= seed_val;
                r_q[seed_ch]   <= r_val;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            valid_q   <= 1'b0;
            out_ch_q  <= '0;
            out_x_q   <= '0;
            out_avg_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= MUL1;
                        busy_q  <= 1'b1;
                    end
                end
                MUL1: state_q <= MUL2;
                MUL2: begin
                    state_q   <= OUT;
                    valid_q   <= 1'b1;
                    out_ch_q  <= ch_q;
                    out_x_q   <= y;
                    out_avg_q <= avg_next;
                end
                OUT: begin
                    if (beat.out_ready) begin
                        valid_q <= 1'b0;
                        ch_q    <= ch_next;
                        state_q <= enable ? MUL1 : IDLE;
                        busy_q  <= enable;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign beat.out_valid = valid_q;
    assign beat.out_ch    = out_ch_q;
    assign beat.out_x     = out_x_q;
    assign beat.out_avg   = out_avg_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_chaotic_ewma_engine.sv
// Directed bench for chaotic_ewma_engine (N=4) with hand-computed expected beats.
module tb_chaotic_ewma_engine;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        seed_load;
    logic [1:0]  seed_ch;
    logic [15:0] seed_val;
    logic [7:0]  r_val;
    logic        busy;
    int          checks;
    int          errors;

    chaotic_ewma_engine_if #(.W(16), .CHW(2)) bus ();

    chaotic_ewma_engine #(
        .W           (16),
        .RW          (8),
        .RFRAC       (5),
        .N           (4),
        .ALPHA_SHIFT (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .seed_load (seed_load),
        .seed_ch   (seed_ch),
        .seed_val  (seed_val),
        .r_val     (r_val),
        .busy      (busy),
        .beat      (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic seed(input logic [1:0] ch, input logic [15:0] val, input logic [7:0] r);
        seed_ch   = ch;
        seed_val  = val;
        r_val     = r;
        seed_load = 1'b1;
        step();
        seed_load = 1'b0;
    endtask

    // Advance at least one cycle, then until a beat is presented.
    task automatic next_beat(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.out_valid && n < 20);
        check(tag, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic check_beat(input string tag, input logic [1:0] ch, input logic [15:0] x,
                              input logic [15:0] avg);
        check({tag, "_ch"}, 32'(bus.out_ch), 32'(ch));
        check({tag, "_x"}, 32'(bus.out_x), 32'(x));
        check({tag, "_avg"}, 32'(bus.out_avg), 32'(avg));
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        enable        = 1'b1;
        seed_load     = 1'b0;
        seed_ch       = '0;
        seed_val      = '0;
        r_val         = '0;
        bus.out_ready = 1'b1;

        // Reset held with enable high.
        repeat (3) step();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check_beat("rst", 2'd0, 16'd0, 16'd0);
        enable = 1'b0;
        reset  = 1'b1;
        step();
        check("post_rst_valid", 32'(bus.out_valid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Basic step and 3-cycle latency.
        seed(2'd0, 16'd3000, 8'd128);
        enable = 1'b1;
        step();
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_c1_valid", 32'(bus.out_valid), 32'd0);
        step();
        check("lat_c2_valid", 32'(bus.out_valid), 32'd0);
        step();
        check("lat_c3_valid", 32'(bus.out_valid), 32'd1);
        check_beat("basic", 2'd0, 16'd11448, 16'd5112);

        // Saturation, then the x=0 fixed point.
        seed(2'd0, 16'd32768, 8'd128);
        for (int i = 0; i < 4; i++) next_beat("sat_wait");
        check_beat("sat", 2'd0, 16'd65535, 16'd40959);
        for (int i = 0; i < 4; i++) next_beat("zero1_wait");
        check_beat("zero1", 2'd0, 16'd0, 16'd30719);
        for (int i = 0; i < 4; i++) next_beat("zero2_wait");
        check_beat("zero2", 2'd0, 16'd0, 16'd23039);

        // Backpressure on the current ch0 beat.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check_beat("bp_hold", 2'd0, 16'd0, 16'd23039);
        end
        bus.out_ready = 1'b1;
        step();
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        step();
        step();
        check("bp_next_valid", 32'(bus.out_valid), 32'd1);
        check("bp_next_ch", 32'(bus.out_ch), 32'd1);

        // Fresh start for round-robin with distinct seeds and gains.
        enable = 1'b0;
        reset  = 1'b0;
        step();
        reset = 1'b1;
        seed(2'd0, 16'd16384, 8'd128);
        seed(2'd1, 16'd32768, 8'd64);
        seed(2'd2, 16'd49152, 8'd32);
        seed(2'd3, 16'd8192, 8'd96);
        enable = 1'b1;
        next_beat("rr0_wait");
        check_beat("rr0", 2'd0, 16'd49152, 16'd24576);
        next_beat("rr1_wait");
        check_beat("rr1", 2'd1, 16'd32768, 16'd32768);
        next_beat("rr2_wait");
        check_beat("rr2", 2'd2, 16'd12288, 16'd39936);
        next_beat("rr3_wait");
        check_beat("rr3", 2'd3, 16'd21504, 16'd11520);
        next_beat("rr4_wait");
        check_beat("rr4", 2'd0, 16'd49152, 16'd30720);

        // Enable dropped during MUL1: ch1 step finishes, then idle.
        step();
        enable = 1'b0;
        next_beat("drop_wait");
        check_beat("drop", 2'd1, 16'd32768, 16'd32768);
        step();
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_valid", 32'(bus.out_valid), 32'd0);
        repeat (3) step();
        check("idle_busy", 32'(busy), 32'd0);

        // Seed collides with ch2 while it is in MUL2.
        enable = 1'b1;
        step();
        check("col_busy", 32'(busy), 32'd1);
        step();
        seed(2'd2, 16'd16384, 8'd128);
        check("col_valid", 32'(bus.out_valid), 32'd1);
        check_beat("col", 2'd2, 16'd9984, 16'd32448);
        for (int i = 0; i < 4; i++) next_beat("col_revisit_wait");
        check_beat("col_revisit", 2'd2, 16'd49152, 16'd24576);

        // Asynchronous reset while a beat is pending.
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_avg", 32'(bus.out_avg), 32'd0);
        reset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
